// File: rtl/sev_seg_mux_pkg.sv
// Shared types and the hex-to-segment table for the multiplexed 7-segment driver.
// Segment order is gfedcba, active low.
package sev_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/sev_seg_mux_if.sv
// Display-data inputs and panel-drive outputs of sev_seg_mux.
// The host drives through master; the mux sits on slave.
interface sev_seg_if #(
  parameter int NDIG     = 4,
  parameter int BRIGHT_W = 4
);
  import sev_seg_pkg::*;

  logic [4*NDIG-1:0]   digits_in;
  logic [NDIG-1:0]     dp_in;
  logic [NDIG-1:0]     blank_in;
  logic                lz_en;
  logic                load;
  logic [BRIGHT_W-1:0] brightness;
  seg_t                seg;
  logic                dp;
  logic [NDIG-1:0]     an;
  logic                frame_tick;

  modport master (
    output digits_in, dp_in, blank_in, lz_en, load, brightness,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  digits_in, dp_in, blank_in, lz_en, load, brightness,
    output seg, dp, an, frame_tick
  );

endinterface

// File: rtl/sev_seg_mux_hex_to_seg.sv
// Combinational nibble to active-low gfedcba segment pattern.
module hex_to_seg
  import sev_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed hex display driver: double-buffered digit set, leading-zero
// suppression, anode PWM with a dead window at each slot start.
module sev_seg_mux
  import sev_seg_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 100000,
  parameter int BRIGHT_W = 4,
  parameter int DEAD     = 16
)(
  input  logic     clk,
  input  logic     rst_n,
  sev_seg_if.slave bus
);

  localparam int          PW     = $clog2(PRESCALE);
  localparam int          IW     = $clog2(NDIG);
  localparam logic [31:0] SPAN   = 32'(PRESCALE - DEAD);
  localparam logic [31:0] DEAD_U = 32'(DEAD);

  logic [PW-1:0]        presc_q;
  logic [IW-1:0]        idx_q;
  logic [NDIG-1:0][3:0] act_dig_q, shd_dig_q;
  logic [NDIG-1:0]      act_dp_q, act_bl_q, shd_dp_q, shd_bl_q;
  logic                 pend_q;
  logic [NDIG-1:0]      an_q;
  seg_t                 seg_q;
  logic                 dp_q, ft_q;

  logic                 slot_end, wrap;
  logic [NDIG-1:0]      sup;
  logic                 zrun;
  logic [3:0]           cur_nib;
  logic                 cur_blank;
  seg_t                 cur_seg;
  logic [31:0]          on_clk, pos;
  logic                 an_on;
  logic [NDIG-1:0]      an_sel;

  assign slot_end = (presc_q == PW'(PRESCALE - 1));
  assign wrap     = slot_end && (idx_q == IW'(NDIG - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (slot_end) begin
      presc_q <= '0;
      idx_q   <= wrap ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // A load landing on the wrap clock bypasses the shadow so it is never a frame late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_dig_q <= '0;
      act_dp_q  <= '0;
      act_bl_q  <= '1;
      shd_dig_q <= '0;
      shd_dp_q  <= '0;
      shd_bl_q  <= '1;
      pend_q    <= 1'b0;
    end else begin
      if (bus.load) begin
        shd_dig_q <= bus.digits_in;
        shd_dp_q  <= bus.dp_in;
        shd_bl_q  <= bus.blank_in;
      end
      if (wrap) begin
        pend_q <= 1'b0;
        if (bus.load) begin
          act_dig_q <= bus.digits_in;
          act_dp_q  <= bus.dp_in;
          act_bl_q  <= bus.blank_in;
        end else if (pend_q) begin
          act_dig_q <= shd_dig_q;
          act_dp_q  <= shd_dp_q;
          act_bl_q  <= shd_bl_q;
        end
      end else if (bus.load) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Zero run from the top digit down; digit 0 always shows.
  always_comb begin
    sup  = '0;
    zrun = bus.lz_en;
    for (int k = NDIG - 1; k > 0; k--) begin
      zrun   = zrun && (act_dig_q[k] == 4'd0);
      sup[k] = zrun;
    end
  end

  assign cur_nib   = act_dig_q[idx_q];
  assign cur_blank = act_bl_q[idx_q] | sup[idx_q];

  hex_to_seg u_hex_to_seg (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

  assign on_clk = ((32'(bus.brightness) + 32'd1) * SPAN) >> BRIGHT_W;
  assign pos    = 32'(presc_q);
  assign an_on  = (pos >= DEAD_U) && (pos < DEAD_U + on_clk);
  assign an_sel = ~({{(NDIG-1){1'b0}}, 1'b1} << idx_q);

  // seg/dp are latched only at slot start, while every anode is still off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      ft_q  <= 1'b0;
    end else begin
      an_q <= an_on ? an_sel : '1;
      ft_q <= wrap;
      if (presc_q == '0) begin
        seg_q <= cur_blank ? SEG_BLANK : cur_seg;
        dp_q  <= cur_blank | ~act_dp_q[idx_q];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_sev_seg_mux.sv
// Scoreboard bench for sev_seg_mux: a cycle-count reference model pushes the
// expected panel state every clock; a monitor pops and compares on the falling edge.
module tb_sev_seg_mux;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 8;
  localparam int BRIGHT_W = 2;
  localparam int DEAD     = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sev_seg_if #(.NDIG(NDIG), .BRIGHT_W(BRIGHT_W)) bus ();

  sev_seg_mux #(
    .NDIG     (NDIG),
    .PRESCALE (PRESCALE),
    .BRIGHT_W (BRIGHT_W),
    .DEAD     (DEAD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NDIG-1:0] an;
    logic [6:0]      seg;
    logic            dp;
    logic            ft;
  } obs_t;

  localparam obs_t DARK = {{NDIG{1'b1}}, 7'b1111111, 1'b1, 1'b0};

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Lit segments (active high, gfedcba) per hex value; the panel wants the inverse.
  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] lit;
    case (v)
      0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
      4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
      8: lit = 7'h7F;  9: lit = 7'h6F; 10: lit = 7'h77; 11: lit = 7'h7C;
     12: lit = 7'h39; 13: lit = 7'h5E; 14: lit = 7'h79; default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  function automatic int nib(input logic [4*NDIG-1:0] v, input int k);
    logic [4*NDIG-1:0] s;
    s = v >> (4 * k);
    return int'(s[3:0]);
  endfunction

  // Reference model: position in the frame is derived from clocks since reset.
  int                t, p, ix, on_t, top;
  logic [4*NDIG-1:0] a_dig, s_dig;
  logic [NDIG-1:0]   a_dp, a_bl, s_dp, s_bl;
  bit                dirty;
  logic [6:0]        m_seg;
  logic              m_dp;
  obs_t              m_e;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      t = 0; a_dig = '0; s_dig = '0; a_dp = '0; s_dp = '0;
      a_bl = '1; s_bl = '1; dirty = 1'b0; m_seg = 7'h7F; m_dp = 1'b1;
      m_e = DARK;
    end else begin
      p  = t % PRESCALE;
      ix = (t / PRESCALE) % NDIG;
      if (p == 0) begin
        top = 0;
        for (int k = 0; k < NDIG; k++) if (nib(a_dig, k) != 0) top = k;
        if (a_bl[ix] || (bus.lz_en && ix > top)) begin
          m_seg = 7'h7F; m_dp = 1'b1;
        end else begin
          m_seg = seg_of(nib(a_dig, ix)); m_dp = ~a_dp[ix];
        end
      end
      on_t     = ((int'(bus.brightness) + 1) * (PRESCALE - DEAD)) / (2 ** BRIGHT_W);
      m_e.an   = '1;
      if (p >= DEAD && p < DEAD + on_t) m_e.an[ix] = 1'b0;
      m_e.seg  = m_seg;
      m_e.dp   = m_dp;
      m_e.ft   = (p == PRESCALE - 1) && (ix == NDIG - 1);
      // Newest data visible at frame start wins.
      if (m_e.ft) begin
        if (bus.load) begin
          a_dig = bus.digits_in; a_dp = bus.dp_in; a_bl = bus.blank_in;
        end else if (dirty) begin
          a_dig = s_dig; a_dp = s_dp; a_bl = s_bl;
        end
        dirty = 1'b0;
      end else if (bus.load) begin
        dirty = 1'b1;
      end
      if (bus.load) begin
        s_dig = bus.digits_in; s_dp = bus.dp_in; s_bl = bus.blank_in;
      end
      t++;
    end
    exp_q.push_back(m_e);
  end

  obs_t mon_e, mon_a;

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.an, bus.seg, bus.dp, bus.frame_tick};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
                 $time, mon_a.an, mon_a.seg, mon_a.dp, mon_a.ft,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.ft);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*NDIG-1:0] d, input logic [NDIG-1:0] dpv,
                         input logic [NDIG-1:0] bl);
    bus.digits_in = d;
    bus.dp_in     = dpv;
    bus.blank_in  = bl;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  task automatic wait_ft();
    int n = 0;
    @(negedge clk);
    while (bus.frame_tick !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL frame_tick_timeout: got no pulse in %0d clocks, want one within 32", n);
    end
  endtask

  task automatic check_dark(input string name);
    obs_t a;
    a = {bus.an, bus.seg, bus.dp, bus.frame_tick};
    checks++;
    if (a !== DARK) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, a, DARK);
    end
  endtask

  initial begin
    bus.digits_in  = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.lz_en      = 1'b0;
    bus.load       = 1'b0;
    bus.brightness = 2'd3;
    tick(3);
    check_dark("reset_state");
    #2 rst_n = 1'b1;

    tick(2);
    do_load(16'h1234, 4'b0000, 4'b0000);
    tick(100);

    bus.lz_en = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    tick(70);
    do_load(16'h0000, 4'b0000, 4'b0000);
    tick(70);
    bus.lz_en = 1'b0;

    wait_ft(); tick(5);
    do_load(16'h1111, 4'b0000, 4'b0000); tick(8);
    do_load(16'h2222, 4'b0000, 4'b0000); tick(40);
    wait_ft();
    do_load(16'h3333, 4'b0000, 4'b0000); tick(70);
    wait_ft(); tick(31);
    do_load(16'h4444, 4'b0000, 4'b0000); tick(40);

    bus.brightness = 2'd0;
    do_load(16'h89AB, 4'b0100, 4'b0001); tick(80);
    bus.brightness = 2'd3; tick(40);

    repeat (30) begin
      bus.brightness = BRIGHT_W'($urandom_range(0, 3));
      bus.lz_en      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0)
        do_load(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)));
      tick($urandom_range(1, 40));
    end

    repeat (300) begin
      bus.brightness = BRIGHT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        do_load(16'($urandom), 4'($urandom), 4'b0000);
      else
        tick(1);
    end

    bus.brightness = 2'd3;
    wait_ft(); tick(10);
    do_load(16'h5678, 4'b0010, 4'b0000);
    tick(3);
    #2 rst_n = 1'b0;
    #1 check_dark("reset_async");
    tick(2);
    #2 rst_n = 1'b1;
    tick(80);
    do_load(16'h0F0A, 4'b1000, 4'b0000);
    tick(70);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
